// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5-8 data bits, none/even/odd/mark parity,
// 1 or 2 stop bits, divisor-based baud. Config is captured per frame at acceptance.
module uart_tx_cfg #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    input  logic [DIV_W-1:0] divisor,
    input  logic [1:0]       data_bits,
    input  logic [1:0]       parity,
    input  logic             stop2
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]       state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] d_r;
    logic [7:0]       sh;
    logic [2:0]       bidx;
    logic [1:0]       nb_r;
    logic             par_en_r;
    logic             par_bit_r;
    logic             stop2_r;
    logic             sidx;

    logic             accept;
    logic [DIV_W-1:0] d_in;
    logic [7:0]       masked;
    logic             par_in;
    logic [2:0]       last_bit;

    always_comb begin
        accept   = valid && ready;
        d_in     = (divisor < DIV_W'(2)) ? DIV_W'(2) : divisor;
        // Bits above the configured width never reach the line or the parity.
        masked   = data & (8'hFF >> (2'd3 - data_bits));
        case (parity)
            2'd1:    par_in = ^masked;
            2'd2:    par_in = ~^masked;
            default: par_in = 1'b1;
        endcase
        last_bit = 3'd4 + {1'b0, nb_r};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tx        <= 1'b1;
            ready     <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
            d_r       <= DIV_W'(2);
            sh        <= '0;
            bidx      <= '0;
            nb_r      <= '0;
            par_en_r  <= 1'b0;
            par_bit_r <= 1'b0;
            stop2_r   <= 1'b0;
            sidx      <= 1'b0;
        end else if (accept) begin
            // Accept can land in IDLE or in the final clock of the last stop bit.
            state     <= S_START;
            tx        <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b1;
            cnt       <= d_in - DIV_W'(1);
            d_r       <= d_in;
            sh        <= masked;
            nb_r      <= data_bits;
            par_en_r  <= (parity != 2'd0);
            par_bit_r <= par_in;
            stop2_r   <= stop2;
        end else begin
            case (state)
                S_START: begin
                    if (cnt == '0) begin
                        state <= S_DATA;
                        tx    <= sh[0];
                        sh    <= sh >> 1;
                        bidx  <= '0;
                        cnt   <= d_r - DIV_W'(1);
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        cnt <= d_r - DIV_W'(1);
                        if (bidx == last_bit) begin
                            if (par_en_r) begin
                                state <= S_PAR;
                                tx    <= par_bit_r;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                                sidx  <= 1'b0;
                            end
                        end else begin
                            tx   <= sh[0];
                            sh   <= sh >> 1;
                            bidx <= bidx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                S_PAR: begin
                    if (cnt == '0) begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                        sidx  <= 1'b0;
                        cnt   <= d_r - DIV_W'(1);
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == '0) begin
                        if (sidx == stop2_r) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            sidx <= 1'b1;
                            cnt  <= d_r - DIV_W'(1);
                        end
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                        // ready is registered, so raise it one edge before the final clock.
                        if (cnt == DIV_W'(1) && sidx == stop2_r) ready <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed frames plus randomized frames,
// compared clock-by-clock against a bit-list reference of each frame.
module tb_uart_tx_cfg;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        tx;
    logic        busy;
    logic [15:0] divisor;
    logic [1:0]  data_bits;
    logic [1:0]  parity;
    logic        stop2;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_cfg #(.DIV_W(16)) dut (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready),
        .tx(tx), .busy(busy), .divisor(divisor), .data_bits(data_bits),
        .parity(parity), .stop2(stop2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: list of line levels, one per bit period, for a whole frame.
    task automatic build_bits(input logic [7:0] b, input int db, input int par,
                              input int s2, output bit bits[$]);
        int n, ones;
        n = 5 + db;
        ones = 0;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(b[i]);
            ones += b[i];
        end
        if (par == 1) bits.push_back(bit'(ones % 2));
        else if (par == 2) bits.push_back(bit'(1 - ones % 2));
        else if (par == 3) bits.push_back(1'b1);
        bits.push_back(1'b1);
        if (s2 != 0) bits.push_back(1'b1);
    endtask

    // Presents a byte, lets the next edge accept it, then checks every clock of the
    // frame; returns while in the frame's last clock so the caller may chain.
    task automatic send(input logic [7:0] b, input int div, input int db, input int par,
                        input int s2, input bit keep_valid, input string tag);
        bit bits[$];
        int d, len;
        build_bits(b, db, par, s2, bits);
        d = (div < 2) ? 2 : div;
        len = bits.size() * d;
        data = b; divisor = 16'(div); data_bits = 2'(db); parity = 2'(par);
        stop2 = 1'(s2); valid = 1'b1;
        tick();
        if (!keep_valid) valid = 1'b0;
        // Config and data wiggled mid-frame must not matter.
        data = 8'($urandom); divisor = 16'($urandom_range(0, 20));
        data_bits = 2'($urandom); parity = 2'($urandom); stop2 = 1'($urandom);
        for (int k = 1; k <= len; k++) begin
            chk({tag, ".tx"}, {31'd0, tx}, {31'd0, bits[(k - 1) / d]});
            chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
            chk({tag, ".ready"}, {31'd0, ready}, {31'd0, k == len});
            if (k < len) tick();
        end
    endtask

    task automatic idle_chk(input string tag);
        valid = 1'b0;
        tick();
        chk({tag, ".idle_tx"}, {31'd0, tx}, 32'd1);
        chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".idle_ready"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; data = '0; divisor = 16'd4;
        data_bits = 2'd3; parity = 2'd0; stop2 = 1'b0;
        tick();
        chk("reset.tx", {31'd0, tx}, 32'd1);
        chk("reset.ready", {31'd0, ready}, 32'd1);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle_chk("post_reset");

        send(8'h55, 4, 3, 0, 0, 1'b0, "8n1_55");
        idle_chk("8n1_55");
        send(8'h83, 3, 2, 1, 1, 1'b0, "7e2_83");
        idle_chk("7e2_83");
        send(8'h1F, 0, 0, 2, 0, 1'b0, "5o1_1f");
        idle_chk("5o1_1f");
        send(8'hA5, 4, 3, 0, 0, 1'b1, "b2b_a5");
        send(8'h3C, 4, 3, 0, 0, 1'b0, "b2b_3c");
        idle_chk("b2b_3c");
        send(8'hC3, 4, 3, 1, 0, 1'b0, "cfg_d4");
        send(8'hC3, 8, 3, 2, 0, 1'b0, "cfg_d8");
        idle_chk("cfg_d8");
        send(8'h6B, 1, 1, 3, 1, 1'b0, "6m2_d1");
        idle_chk("6m2_d1");

        for (int r = 0; r < 24; r++) begin
            send(8'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                 1'($urandom), "rand");
            if ($urandom_range(0, 2) == 0) idle_chk("rand");
        end
        idle_chk("rand_end");

        // Reset in the middle of an 8N1 frame.
        data = 8'h00; divisor = 16'd4; data_bits = 2'd3; parity = 2'd0; stop2 = 1'b0;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (9) tick();
        chk("midframe.busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst.tx", {31'd0, tx}, 32'd1);
        chk("midrst.ready", {31'd0, ready}, 32'd1);
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        idle_chk("after_midrst");
        send(8'h5A, 2, 3, 1, 0, 1'b0, "after_rst_frame");
        idle_chk("after_rst_frame");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
